// File: rtl/pokemon_gfx_pkg.sv
// Shared graphics types and constants for the sprite/map blit path.
// Framebuffer geometry, colour key and the blitter state encoding live here.
package pokemon_gfx_pkg;

  typedef logic [18:0] addr_t;
  typedef logic [23:0] rgb_t;

  localparam int   FB_W            = 240;
  localparam int   FB_H            = 160;
  localparam rgb_t TRANSPARENT_KEY = 24'hFF00FF;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    FINISH
  } blit_state_t;

endpackage

// File: rtl/blit_scan_counter.sv
// Raster cx/cy counter for the blit window.
// Walks columns first, then rows, and flags the final pixel of the window.
module blit_scan_counter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic       advance_i,
  input  logic [7:0] width_i,
  input  logic [7:0] height_i,
  output logic [7:0] cx_o,
  output logic [7:0] cy_o,
  output logic       last_o
);

  logic [7:0] cx_q, cx_d;
  logic [7:0] cy_q, cy_d;
  logic       row_end;

  always_comb begin
    row_end = (cx_q == width_i - 8'd1);
    cx_d    = cx_q;
    cy_d    = cy_q;
    if (load_i) begin
      cx_d = '0;
      cy_d = '0;
    end else if (advance_i) begin
      if (row_end) begin
        cx_d = '0;
        cy_d = cy_q + 8'd1;
      end else begin
        cx_d = cx_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx_o   = cx_q;
  assign cy_o   = cy_q;
  assign last_o = row_end && (cy_q == height_i - 8'd1);

endmodule

// File: rtl/sprite_blitter.sv
// Rectangle copy engine: scans a source window, then writes the decoded RGB
// into the framebuffer one cycle later with colour-key and screen clipping.
module sprite_blitter #(
  parameter int          FB_W = pokemon_gfx_pkg::FB_W,
  parameter int          FB_H = pokemon_gfx_pkg::FB_H,
  parameter logic [23:0] KEY  = pokemon_gfx_pkg::TRANSPARENT_KEY
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic [18:0] src_base,
  input  logic [9:0]  src_stride,
  input  logic [7:0]  width,
  input  logic [7:0]  height,
  input  logic [7:0]  dst_x,
  input  logic [7:0]  dst_y,
  input  logic        key_en,
  output logic [18:0] src_read_address,
  input  logic [23:0] src_data,
  output logic [18:0] fb_write_address,
  output logic [23:0] fb_data,
  output logic        fb_we,
  output logic        busy,
  output logic        done
);

  import pokemon_gfx_pkg::*;

  blit_state_t state_q, state_d;

  addr_t      src_base_q;
  logic [9:0] stride_q;
  logic [7:0] width_q, height_q, dst_x_q, dst_y_q;
  logic       key_en_q;

  logic       valid_q, valid_d;
  logic       clip_q, clip_d;
  addr_t      wr_addr_q, wr_addr_d;

  logic       load, advance, last;
  logic [7:0] cx, cy;
  logic [8:0] sum_x, sum_y;

  blit_scan_counter u_counter (
    .clk_i     (Clk),
    .rst_ni    (Reset_n),
    .load_i    (load),
    .advance_i (advance),
    .width_i   (width_q),
    .height_i  (height_q),
    .cx_o      (cx),
    .cy_o      (cy),
    .last_o    (last)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (width == 8'd0 || height == 8'd0) ? FINISH : SCAN;
        end
      end
      SCAN: begin
        advance = 1'b1;
        if (last) state_d = DRAIN;
      end
      DRAIN:   state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Destination sums are 9 bits wide so off-screen pixels clip instead of wrapping.
  always_comb begin
    sum_x     = {1'b0, dst_x_q} + {1'b0, cx};
    sum_y     = {1'b0, dst_y_q} + {1'b0, cy};
    clip_d    = (sum_x >= 9'(FB_W)) || (sum_y >= 9'(FB_H));
    wr_addr_d = addr_t'(sum_y) * addr_t'(FB_W) + addr_t'(sum_x);
    valid_d   = (state_q == SCAN);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      src_base_q <= '0;
      stride_q   <= '0;
      width_q    <= '0;
      height_q   <= '0;
      dst_x_q    <= '0;
      dst_y_q    <= '0;
      key_en_q   <= 1'b0;
      valid_q    <= 1'b0;
      clip_q     <= 1'b0;
      wr_addr_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      if (state_q == IDLE && start) begin
        src_base_q <= src_base;
        stride_q   <= src_stride;
        width_q    <= width;
        height_q   <= height;
        dst_x_q    <= dst_x;
        dst_y_q    <= dst_y;
        key_en_q   <= key_en;
      end
      if (valid_d) begin
        clip_q    <= clip_d;
        wr_addr_q <= wr_addr_d;
      end
    end
  end

  assign src_read_address = (state_q == SCAN)
                          ? src_base_q + addr_t'(cy) * addr_t'(stride_q) + addr_t'(cx)
                          : '0;

  // Source RAM output is registered, so the write stage lines up with valid_q.
  assign fb_we            = valid_q && !clip_q && !(key_en_q && (src_data == KEY));
  assign fb_data          = valid_q ? src_data : '0;
  assign fb_write_address = wr_addr_q;
  assign busy             = (state_q == SCAN) || (state_q == DRAIN);
  assign done             = (state_q == FINISH);

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed self-checking bench for sprite_blitter with a registered source RAM
// model and a framebuffer write recorder.
module tb_sprite_blitter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        start;
  logic [18:0] src_base;
  logic [9:0]  src_stride;
  logic [7:0]  width, height, dst_x, dst_y;
  logic        key_en;
  logic [18:0] src_read_address;
  logic [23:0] src_data;
  logic [18:0] fb_write_address;
  logic [23:0] fb_data;
  logic        fb_we, busy, done;

  logic [23:0] srcMem [0:1023];
  logic [18:0] wrAddr [$];
  logic [23:0] wrData [$];

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  sprite_blitter dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .start            (start),
    .src_base         (src_base),
    .src_stride       (src_stride),
    .width            (width),
    .height           (height),
    .dst_x            (dst_x),
    .dst_y            (dst_y),
    .key_en           (key_en),
    .src_read_address (src_read_address),
    .src_data         (src_data),
    .fb_write_address (fb_write_address),
    .fb_data          (fb_data),
    .fb_we            (fb_we),
    .busy             (busy),
    .done             (done)
  );

  always @(posedge Clk) src_data <= srcMem[src_read_address[9:0]];

  always @(negedge Clk) begin
    if (fb_we) begin
      wrAddr.push_back(fb_write_address);
      wrData.push_back(fb_data);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic fillIdentity();
    for (int i = 0; i < 1024; i++) srcMem[i] = 24'(i);
  endtask

  // Runs one blit; doneAt is the cycle index (first cycle after start = 1) of done.
  task automatic applyStimulus(input logic [18:0] base, input logic [9:0] stride,
                               input logic [7:0] w, input logic [7:0] h,
                               input logic [7:0] dx, input logic [7:0] dy,
                               input logic ke, input int midStartAt,
                               output int doneAt, output logic busyFirst);
    wrAddr.delete();
    wrData.delete();
    doneAt    = -1;
    busyFirst = 1'b0;
    @(negedge Clk);
    src_base = base; src_stride = stride; width = w; height = h;
    dst_x = dx; dst_y = dy; key_en = ke; start = 1'b1;
    @(negedge Clk);
    for (int n = 1; n <= 200; n++) begin
      if (n == 1) busyFirst = busy;
      if (n == midStartAt) begin
        start = 1'b1;
        width = 8'd1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        doneAt = n;
        break;
      end
      @(negedge Clk);
    end
    start = 1'b0;
    @(negedge Clk);
  endtask

  int   doneAt;
  logic busyFirst;
  logic [18:0] expAddr1 [8] = '{19'd4810, 19'd4811, 19'd4812, 19'd4813,
                                19'd5050, 19'd5051, 19'd5052, 19'd5053};
  logic [23:0] expData1 [8] = '{24'd0, 24'd1, 24'd2, 24'd3,
                                24'd16, 24'd17, 24'd18, 24'd19};
  logic [18:0] expAddrKey [6] = '{19'd4810, 19'd4812, 19'd4813,
                                  19'd5050, 19'd5052, 19'd5053};

  initial begin
    fillIdentity();
    Reset_n = 1'b0; start = 1'b0; src_base = '0; src_stride = '0;
    width = '0; height = '0; dst_x = '0; dst_y = '0; key_en = 1'b0;
    repeat (3) @(negedge Clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_we", 32'(fb_we), 32'd0);
    checkOutput("rst_wr_addr", 32'(fb_write_address), 32'd0);
    checkOutput("rst_fb_data", 32'(fb_data), 32'd0);
    checkOutput("rst_src_addr", 32'(src_read_address), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    $display("[TB] opaque 4x2 blit");
    applyStimulus(19'd0, 10'd16, 8'd4, 8'd2, 8'd10, 8'd20, 1'b0, 0, doneAt, busyFirst);
    checkOutput("opaque_count", 32'(wrAddr.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("opaque_addr%0d", i), 32'(wrAddr[i]), 32'(expAddr1[i]));
      checkOutput($sformatf("opaque_data%0d", i), 32'(wrData[i]), 32'(expData1[i]));
    end
    checkOutput("opaque_done", 32'(doneAt), 32'd10);
    checkOutput("opaque_busy", 32'(busyFirst), 32'd1);

    $display("[TB] transparency key");
    srcMem[1]  = 24'hFF00FF;
    srcMem[17] = 24'hFF00FF;
    applyStimulus(19'd0, 10'd16, 8'd4, 8'd2, 8'd10, 8'd20, 1'b1, 0, doneAt, busyFirst);
    checkOutput("key_count", 32'(wrAddr.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("key_addr%0d", i), 32'(wrAddr[i]), 32'(expAddrKey[i]));
    applyStimulus(19'd0, 10'd16, 8'd4, 8'd2, 8'd10, 8'd20, 1'b0, 0, doneAt, busyFirst);
    checkOutput("nokey_count", 32'(wrAddr.size()), 32'd8);
    checkOutput("nokey_data1", 32'(wrData[1]), 32'hFF00FF);
    checkOutput("nokey_addr5", 32'(wrAddr[5]), 32'd5051);
    fillIdentity();

    $display("[TB] clipping 8x8 at screen corner");
    applyStimulus(19'd0, 10'd16, 8'd8, 8'd8, 8'd236, 8'd156, 1'b0, 0, doneAt, busyFirst);
    checkOutput("clip_count", 32'(wrAddr.size()), 32'd16);
    checkOutput("clip_first_addr", 32'(wrAddr[0]), 32'd37676);
    checkOutput("clip_first_data", 32'(wrData[0]), 32'd0);
    checkOutput("clip_last_addr", 32'(wrAddr[15]), 32'd38399);
    checkOutput("clip_last_data", 32'(wrData[15]), 32'h33);
    checkOutput("clip_done", 32'(doneAt), 32'd66);

    $display("[TB] empty window");
    applyStimulus(19'd0, 10'd16, 8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 0, doneAt, busyFirst);
    checkOutput("empty_done", 32'(doneAt), 32'd1);
    checkOutput("empty_count", 32'(wrAddr.size()), 32'd0);
    checkOutput("empty_busy", 32'(busyFirst), 32'd0);

    $display("[TB] start while busy");
    applyStimulus(19'd0, 10'd16, 8'd4, 8'd2, 8'd10, 8'd20, 1'b0, 3, doneAt, busyFirst);
    checkOutput("busy_start_count", 32'(wrAddr.size()), 32'd8);
    checkOutput("busy_start_done", 32'(doneAt), 32'd10);
    checkOutput("busy_start_last", 32'(wrAddr[7]), 32'd5053);

    $display("[TB] reset mid-blit");
    wrAddr.delete();
    wrData.delete();
    @(negedge Clk);
    src_base = '0; src_stride = 10'd16; width = 8'd4; height = 8'd4;
    dst_x = 8'd0; dst_y = 8'd0; key_en = 1'b0; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    checkOutput("midrst_we", 32'(fb_we), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    checkOutput("midrst_idle_busy", 32'(busy), 32'd0);
    applyStimulus(19'd0, 10'd16, 8'd4, 8'd4, 8'd0, 8'd0, 1'b0, 0, doneAt, busyFirst);
    checkOutput("after_rst_count", 32'(wrAddr.size()), 32'd16);
    checkOutput("after_rst_done", 32'(doneAt), 32'd18);
    checkOutput("after_rst_last_addr", 32'(wrAddr[15]), 32'd723);
    checkOutput("after_rst_last_data", 32'(wrData[15]), 32'h33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Rectangle copy engine between the sprite/map source RAMs (map RAM, character RAM) and the framebuffer RAM. On a start pulse it scans a W×H window of a source sheet and presents the source read address. It takes back the decoded 24-bit RGB one cycle later and drives framebuffer writes at a destination position, skipping the transparency key colour and pixels that fall outside the screen. The game/scene FSM drives it to compose each frame: background from the map, then characters on top.

## Interface
Parameters:
- FB_W, 240, framebuffer width in pixels
- FB_H, 160, framebuffer height in pixels (FB_W*FB_H = 38400 entries)
- KEY, 24'hFF00FF, transparency key colour (the source RAMs' default decode)

Ports:
- Clk  in  1  system clock, all logic on posedge
- Reset_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- src_base  in  19  source address of window pixel (0,0)
- src_stride  in  10  source sheet row pitch in pixels
- width  in  8  window width in pixels (0 = empty)
- height  in  8  window height in pixels (0 = empty)
- dst_x  in  8  destination column of window pixel (0,0)
- dst_y  in  8  destination row of window pixel (0,0)
- key_en  in  1  1 = pixels equal to KEY are not written
- src_read_address  out  19  to source RAM read_address
- src_data  in  24  from source RAM data_Out (valid 1 cycle after address)
- fb_write_address  out  19  to framebuffer write_address
- fb_data  out  24  to framebuffer data_In
- fb_we  out  1  framebuffer write enable
- busy  out  1  high while a blit is in progress
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SCAN, DRAIN, FINISH.
- IDLE: on start, latch all request inputs. Clear counters cx, cy. Go to SCAN, or to FINISH if width==0 or height==0.
- SCAN: each cycle present src_read_address = src_base + cy*src_stride + cx (19-bit, wraps mod 2^19). Push into a 1-deep pipeline: valid, destination address, clip flag.
- Counter advance: cx increments. At cx==width-1, cx resets to 0 and cy increments. The cycle that issues (width-1, height-1) moves to DRAIN.
- Write stage, one cycle after issue:
  - fb_we = valid & ~clip & ~(key_en & src_data==KEY)
  - fb_data = src_data
  - fb_write_address = (dst_y+cy)*FB_W + (dst_x+cx)
- Clip rule: clip = (dst_x+cx ≥ FB_W) | (dst_y+cy ≥ FB_H). Sums are computed 9-bit, so no wrap. Clipped pixels are read but never written.
- DRAIN: one cycle with no new issue; the last write completes. Then FINISH.
- FINISH: done=1 for one cycle, busy=0, then IDLE.
- start while not IDLE is ignored; request inputs may change freely after the start cycle.
- Reset_n low at any clock edge, including mid-blit: state→IDLE, pipeline valid cleared, no further writes.

## Timing
- Reset values: busy=0, done=0, fb_we=0, fb_write_address=0, fb_data=0, src_read_address=0.
- Start sampled at edge E0. busy=1 from E0+1. Pixel k (raster order) is issued in cycle E0+1+k, and its write, if any, occurs in cycle E0+2+k.
- For N=width*height>0: the last write is in cycle E0+1+N (DRAIN), and done=1 / busy=0 in cycle E0+2+N. Throughput is 1 pixel/clock.
- For N=0: done=1 in cycle E0+1; busy never rises; no writes.
- A new start is accepted in the cycle after done (IDLE). Minimum blit-to-blit gap is 1 idle cycle.
- fb_we, fb_write_address and fb_data are registered and change together.

## Structure
- Shared package pokemon_gfx_pkg holds:
  - typedef addr_t = logic[18:0]
  - typedef rgb_t = logic[23:0]
  - constants FB_W, FB_H, TRANSPARENT_KEY
  - blit_state_t enum
- One sub-module, blit_scan_counter: a cx/cy raster counter with load, advance and last-pixel flag. The top holds the FSM, address multiply-adds and the write pipeline stage.

## Test plan
- Opaque blit: src_base=0, stride=16, 4×2 window, dst (10,20), source = address value, key_en=0.
  - Expect 8 writes to 4810..4813 and 5050..5053, in order, with data = source addresses 0..3 and 16..19.
  - Expect done exactly 10 cycles after start.
- Transparency: same window with source pixels 1 and 5 = FF00FF and key_en=1. Expect 6 writes with those two addresses absent. With key_en=0, expect all 8 writes.
- Clipping: 8×8 window at dst (236,156).
  - Expect only the 4×4 in-screen pixels written, max address 38399.
  - Expect done still at start+66.
- Empty and busy: width=0 → done at start+1 with no fb_we. A start asserted mid-blit leaves the write count and done timing unchanged.
- Reset mid-op: Reset_n low 3 cycles into a 4×4 blit. Expect fb_we=0, busy=0 and done=0 from the next edge. A following fresh start completes normally.
